ahb_bus_arbiter: RTL and testbench

- Shares the single AHB address/data path between `MASTER_NUM` bus masters.
- Takes each master's HBUSREQ/HLOCK and produces one-hot HGRANT, plus HMASTER (current address-phase owner) for the address/control/write-data muxes.
- Arbitration is round-robin. Ownership changes only at transfer boundaries that are legal in AHB.
- Sits beside the decoder and response multiplexor.

---
 rtl/ahb_pkg.sv | 62 ++++++
 rtl/ahb_bus_arbiter_rr_picker.sv | 31 +++
 rtl/ahb_bus_arbiter.sv | 131 +++++++++++++
 tb/tb_ahb_bus_arbiter.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/ahb_pkg.sv
// Shared AHB encodings, burst length helpers and arbiter state type.
// AHB_ARB_LOCK_EN adds the LOCKED state for HLOCK-aware arbitration.
package ahb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HBURST_SINGLE = 3'b000;
  localparam logic [2:0] HBURST_INCR   = 3'b001;
  localparam logic [2:0] HBURST_WRAP4  = 3'b010;
  localparam logic [2:0] HBURST_INCR4  = 3'b011;
  localparam logic [2:0] HBURST_WRAP8  = 3'b100;
  localparam logic [2:0] HBURST_INCR8  = 3'b101;
  localparam logic [2:0] HBURST_WRAP16 = 3'b110;
  localparam logic [2:0] HBURST_INCR16 = 3'b111;

  localparam int CNT_W = 4;

`ifdef AHB_ARB_LOCK_EN
  typedef enum logic [1:0] {
    ARB_PARK,
    ARB_OWN,
    ARB_BURST,
    ARB_LOCKED
  } arb_state_e;
`else
  typedef enum logic [1:0] {
    ARB_PARK,
    ARB_OWN,
    ARB_BURST
  } arb_state_e;
`endif

  function automatic logic [4:0] burst_beats(
    input logic [2:0] hburst
  );
    case (hburst)
      HBURST_WRAP4,
      HBURST_INCR4:  burst_beats = 5'd4;
      HBURST_WRAP8,
      HBURST_INCR8:  burst_beats = 5'd8;
      HBURST_WRAP16,
      HBURST_INCR16: burst_beats = 5'd16;
      default:       burst_beats = 5'd0;
    endcase
  endfunction

  // Beats still owed once the NONSEQ itself is accepted.
  function automatic logic [CNT_W-1:0] burst_reload(
    input logic [2:0] hburst
  );
    logic [4:0] b;
    b = burst_beats(hburst);
    if (b == 5'd0)
      burst_reload = '0;
    else
      burst_reload = CNT_W'(b - 5'd1);
  endfunction

endpackage

// File: rtl/ahb_bus_arbiter_rr_picker.sv
// Combinational round-robin picker: scans upward from ptr+1 with wrap,
// returning the one-hot winner, its index and a valid flag.
module rr_picker #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx,
  output logic          valid
);

  logic [IW-1:0] j;

  always_comb begin
    grant = '0;
    idx   = ptr;
    valid = 1'b0;
    j     = '0;
    for (int i = 1; i <= N; i++) begin
      j = IW'((int'(ptr) + i) % N);
      if (!valid && req[j]) begin
        valid    = 1'b1;
        grant[j] = 1'b1;
        idx      = j;
      end
    end
  end

endmodule

// File: rtl/ahb_bus_arbiter.sv
// Round-robin AHB arbiter with burst-aware handover.
// Define AHB_ARB_LOCK_EN to honour HLOCK and drive HMASTLOCK.
module ahb_bus_arbiter
  import ahb_pkg::*;
#(
  parameter int MASTER_NUM     = 4,
  parameter int DEFAULT_MASTER = 0,
  parameter int HBURST_WIDTH   = 3
) (
  input  logic                          HCLK,
  input  logic                          HRST,
  input  logic [MASTER_NUM-1:0]         HBUSREQ,
  input  logic [MASTER_NUM-1:0]         HLOCK,
  input  logic [1:0]                    HTRANS,
  input  logic [HBURST_WIDTH-1:0]       HBURST,
  input  logic                          HREADY,
  output logic [MASTER_NUM-1:0]         HGRANT,
  output logic [$clog2(MASTER_NUM)-1:0] HMASTER,
  output logic                          HMASTLOCK
);

  localparam int IW = $clog2(MASTER_NUM);
  localparam logic [MASTER_NUM-1:0] DEF_GRANT =
    MASTER_NUM'(1) << DEFAULT_MASTER;

  arb_state_e state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [IW-1:0] ptr_q;
  logic [IW-1:0] gidx;
  logic [MASTER_NUM-1:0] pick_grant;
  logic [IW-1:0] pick_idx;
  logic pick_valid;
  logic accepted;
  logic lock_hold;
  logic arb;

  rr_picker #(
    .N  (MASTER_NUM),
    .IW (IW)
  ) u_pick (
    .req   (HBUSREQ),
    .ptr   (ptr_q),
    .grant (pick_grant),
    .idx   (pick_idx),
    .valid (pick_valid)
  );

  always_comb begin
    gidx = '0;
    for (int i = 0; i < MASTER_NUM; i++)
      if (HGRANT[i]) gidx = IW'(i);
  end

  assign accepted = HREADY & HTRANS[1];

  always_comb begin
    cnt_d = cnt_q;
    if (HREADY) begin
      unique case (HTRANS)
        HTRANS_NONSEQ: cnt_d = burst_reload(HBURST[2:0]);
        HTRANS_SEQ:
          if (cnt_q != '0) cnt_d = cnt_q - CNT_W'(1);
        HTRANS_IDLE:   cnt_d = '0;
        HTRANS_BUSY:   cnt_d = cnt_q;
      endcase
    end
  end

`ifdef AHB_ARB_LOCK_EN
  logic owner_lock;
  assign owner_lock = HLOCK[gidx];
  // After HLOCK drops, the next accepted transfer still belongs to the lock.
  assign lock_hold = owner_lock |
    ((state_q == ARB_LOCKED) & ~accepted);
`else
  assign lock_hold = 1'b0 & (|HLOCK);
`endif

  assign arb = HREADY & (cnt_d == '0) & ~lock_hold;

  always_comb begin
    state_d = state_q;
`ifdef AHB_ARB_LOCK_EN
    if (owner_lock)
      state_d = ARB_LOCKED;
    else if (state_q == ARB_LOCKED && !arb)
      state_d = ARB_LOCKED;
    else
`endif
    if (cnt_d != '0)
      state_d = ARB_BURST;
    else if (arb)
      state_d = pick_valid ? ARB_OWN : ARB_PARK;
    else
      state_d = state_q;
  end

  always_ff @(posedge HCLK) begin
    if (HRST) begin
      HGRANT  <= DEF_GRANT;
      HMASTER <= IW'(DEFAULT_MASTER);
      cnt_q   <= '0;
      ptr_q   <= IW'(DEFAULT_MASTER);
      state_q <= ARB_PARK;
    end else if (HREADY) begin
      cnt_q   <= cnt_d;
      HMASTER <= gidx;
      state_q <= state_d;
      if (arb) begin
        if (pick_valid) begin
          HGRANT <= pick_grant;
          ptr_q  <= pick_idx;
        end else begin
          HGRANT <= DEF_GRANT;
        end
      end
    end
  end

`ifdef AHB_ARB_LOCK_EN
  always_ff @(posedge HCLK) begin
    if (HRST)
      HMASTLOCK <= 1'b0;
    else if (HREADY)
      HMASTLOCK <= owner_lock;
  end
`else
  assign HMASTLOCK = 1'b0;
`endif

endmodule

// File: tb/tb_ahb_bus_arbiter.sv
// Directed self-checking bench for ahb_bus_arbiter (4 masters, default 0).
// Lock expectations switch with AHB_ARB_LOCK_EN.
module tb_ahb_bus_arbiter;
  import ahb_pkg::*;

  logic       HCLK = 1'b0;
  logic       HRST;
  logic [3:0] HBUSREQ;
  logic [3:0] HLOCK;
  logic [1:0] HTRANS;
  logic [2:0] HBURST;
  logic       HREADY;
  logic [3:0] HGRANT;
  logic [1:0] HMASTER;
  logic       HMASTLOCK;

  int checks = 0;
  int failures = 0;

  logic [3:0] eg_b [4] = '{4'b0010, 4'b1000, 4'b0010, 4'b1000};
  logic [1:0] em_b [4] = '{2'd0, 2'd1, 2'd3, 2'd1};

  logic [3:0] req_e  [7] = '{4'b0100, 4'b1111, 4'b1111, 4'b1111,
                             4'b1111, 4'b1111, 4'b1111};
  logic [3:0] lock_e [7] = '{4'b0100, 4'b0100, 4'b0100, 4'b0100,
                             4'b0100, 4'b0100, 4'b0000};
  logic [1:0] tr_e   [7] = '{HTRANS_IDLE, HTRANS_IDLE, HTRANS_NONSEQ,
                             HTRANS_NONSEQ, HTRANS_NONSEQ, HTRANS_NONSEQ,
                             HTRANS_NONSEQ};
`ifdef AHB_ARB_LOCK_EN
  logic [3:0] eg_e [7] = '{4'b0100, 4'b0100, 4'b0100, 4'b0100,
                           4'b0100, 4'b0100, 4'b1000};
  logic       el_e [7] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
`else
  logic [3:0] eg_e [7] = '{4'b0100, 4'b1000, 4'b0001, 4'b0010,
                           4'b0100, 4'b1000, 4'b0001};
  logic       el_e [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
`endif

  ahb_bus_arbiter #(
    .MASTER_NUM     (4),
    .DEFAULT_MASTER (0),
    .HBURST_WIDTH   (3)
  ) dut (
    .HCLK      (HCLK),
    .HRST      (HRST),
    .HBUSREQ   (HBUSREQ),
    .HLOCK     (HLOCK),
    .HTRANS    (HTRANS),
    .HBURST    (HBURST),
    .HREADY    (HREADY),
    .HGRANT    (HGRANT),
    .HMASTER   (HMASTER),
    .HMASTLOCK (HMASTLOCK)
  );

  always #5 HCLK = ~HCLK;

  task automatic drv(input logic [3:0] req, input logic [1:0] tr,
                     input logic [2:0] bu, input logic rdy);
    HBUSREQ = req;
    HTRANS  = tr;
    HBURST  = bu;
    HREADY  = rdy;
    @(posedge HCLK);
    #1;
  endtask

  task automatic chk_g(input string tag, input logic [3:0] e);
    checks++;
    assert (HGRANT === e) else begin
      failures++;
      $error("FAIL %s HGRANT observed=%b expected=%b", tag, HGRANT, e);
    end
  endtask

  task automatic chk_m(input string tag, input logic [1:0] e);
    checks++;
    assert (HMASTER === e) else begin
      failures++;
      $error("FAIL %s HMASTER observed=%0d expected=%0d", tag, HMASTER, e);
    end
  endtask

  task automatic chk_l(input string tag, input logic e);
    checks++;
    assert (HMASTLOCK === e) else begin
      failures++;
      $error("FAIL %s HMASTLOCK observed=%b expected=%b", tag, HMASTLOCK, e);
    end
  endtask

  task automatic chk_c(input string tag, input logic [3:0] e);
    checks++;
    assert (dut.cnt_q === e) else begin
      failures++;
      $error("FAIL %s count observed=%0d expected=%0d", tag, dut.cnt_q, e);
    end
  endtask

  initial begin
    HRST    = 1'b1;
    HBUSREQ = '0;
    HLOCK   = '0;
    HTRANS  = HTRANS_IDLE;
    HBURST  = HBURST_SINGLE;
    HREADY  = 1'b1;
    @(posedge HCLK);
    @(posedge HCLK);
    #1;
    chk_g("rst", 4'b0001);
    chk_m("rst", 2'd0);
    chk_l("rst", 1'b0);
    chk_c("rst", 4'd0);
    HRST = 1'b0;

    for (int i = 0; i < 10; i++) begin
      drv(4'b0000, HTRANS_IDLE, HBURST_SINGLE, 1'b1);
      chk_g($sformatf("park%0d", i), 4'b0001);
      chk_m($sformatf("park%0d", i), 2'd0);
    end

    for (int i = 0; i < 4; i++) begin
      drv(4'b1010, HTRANS_NONSEQ, HBURST_SINGLE, 1'b1);
      chk_g($sformatf("single%0d", i), eg_b[i]);
      chk_m($sformatf("single%0d", i), em_b[i]);
    end

    drv(4'b0010, HTRANS_IDLE, HBURST_SINGLE, 1'b1);
    chk_g("incr8_pre0", 4'b0010);
    chk_m("incr8_pre0", 2'd3);
    drv(4'b0010, HTRANS_IDLE, HBURST_SINGLE, 1'b1);
    chk_g("incr8_pre1", 4'b0010);
    chk_m("incr8_pre1", 2'd1);
    drv(4'b0010, HTRANS_NONSEQ, HBURST_INCR8, 1'b1);
    chk_c("incr8_b1", 4'd7);
    chk_g("incr8_b1", 4'b0010);
    drv(4'b0110, HTRANS_SEQ, HBURST_INCR8, 1'b1);
    chk_c("incr8_b2", 4'd6);
    chk_g("incr8_b2", 4'b0010);
    drv(4'b0110, HTRANS_SEQ, HBURST_INCR8, 1'b1);
    chk_c("incr8_b3", 4'd5);
    for (int i = 0; i < 3; i++) begin
      drv(4'b0110, HTRANS_SEQ, HBURST_INCR8, 1'b0);
      chk_c($sformatf("incr8_stall%0d", i), 4'd5);
      chk_g($sformatf("incr8_stall%0d", i), 4'b0010);
      chk_m($sformatf("incr8_stall%0d", i), 2'd1);
    end
    for (int i = 0; i < 4; i++) begin
      drv(4'b0110, HTRANS_SEQ, HBURST_INCR8, 1'b1);
      chk_c($sformatf("incr8_b%0d", i + 4), 4'(4 - i));
      chk_g($sformatf("incr8_b%0d", i + 4), 4'b0010);
    end
    drv(4'b0110, HTRANS_SEQ, HBURST_INCR8, 1'b1);
    chk_c("incr8_b8", 4'd0);
    chk_g("incr8_b8", 4'b0100);
    chk_m("incr8_b8", 2'd1);

    drv(4'b1000, HTRANS_IDLE, HBURST_SINGLE, 1'b1);
    chk_g("incr16_pre0", 4'b1000);
    chk_m("incr16_pre0", 2'd2);
    drv(4'b1000, HTRANS_IDLE, HBURST_SINGLE, 1'b1);
    chk_m("incr16_pre1", 2'd3);
    drv(4'b1001, HTRANS_NONSEQ, HBURST_INCR16, 1'b1);
    chk_c("incr16_b1", 4'd15);
    chk_g("incr16_b1", 4'b1000);
    for (int i = 0; i < 4; i++) begin
      drv(4'b1001, HTRANS_SEQ, HBURST_INCR16, 1'b1);
      chk_c($sformatf("incr16_b%0d", i + 2), 4'(14 - i));
      chk_g($sformatf("incr16_b%0d", i + 2), 4'b1000);
    end
    drv(4'b1001, HTRANS_IDLE, HBURST_INCR16, 1'b1);
    chk_c("incr16_early", 4'd0);
    chk_g("incr16_early", 4'b0001);

    for (int i = 0; i < 7; i++) begin
      HLOCK = lock_e[i];
      drv(req_e[i], tr_e[i], HBURST_SINGLE, 1'b1);
      chk_g($sformatf("lock%0d", i), eg_e[i]);
      chk_l($sformatf("lock%0d", i), el_e[i]);
    end

    HLOCK = 4'b0000;
    drv(4'b0010, HTRANS_IDLE, HBURST_SINGLE, 1'b1);
    chk_g("wrap4_pre0", 4'b0010);
    drv(4'b0010, HTRANS_IDLE, HBURST_SINGLE, 1'b1);
    chk_m("wrap4_pre1", 2'd1);
    drv(4'b0010, HTRANS_NONSEQ, HBURST_WRAP4, 1'b1);
    chk_c("wrap4_b1", 4'd3);
    drv(4'b0010, HTRANS_SEQ, HBURST_WRAP4, 1'b1);
    chk_c("wrap4_b2", 4'd2);
    HRST = 1'b1;
    drv(4'b0010, HTRANS_SEQ, HBURST_WRAP4, 1'b0);
    chk_g("midrst", 4'b0001);
    chk_m("midrst", 2'd0);
    chk_c("midrst", 4'd0);
    chk_l("midrst", 1'b0);
    HRST = 1'b0;
    drv(4'b1111, HTRANS_IDLE, HBURST_SINGLE, 1'b1);
    chk_g("post_rst_ptr", 4'b0010);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
